// File: rtl/regfile32.sv
// rtl/regfile32.sv - 32 x 32-bit register file, two combinational read ports, one write port
//
// Purpose:
//   General-purpose register file R0..R31. R0 is hard-wired to zero. Writes
//   happen on the rising clock edge and are blocked during reset. Reads are
//   purely combinational.
//
// Configuration:
//   REGFILE32_BYPASS_EN - when defined, a read port whose address matches an
//   active write forwards the write data in the same cycle.
//
// Ports:
//   clk     in   1   clock, writes on rising edge
//   reset   in   1   asynchronous active-low reset, clears R1..R31
//   S_Addr  in   5   read port S address
//   T_Addr  in   5   read port T address
//   D_Addr  in   5   write address
//   D       in  32   write data
//   D_En    in   1   write enable, active-high
//   S       out 32   contents of R[S_Addr]
//   T       out 32   contents of R[T_Addr]

module regfile32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  S_Addr,
  input  logic [4:0]  T_Addr,
  input  logic [4:0]  D_Addr,
  input  logic [31:0] D,
  input  logic        D_En,
  output logic [31:0] S,
  output logic [31:0] T
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];
  logic        wr_en;

  // Writes to R0 are dropped here so R0 never leaves its reset value.
  assign wr_en = D_En && (D_Addr != 5'd0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[D_Addr] = D;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    S = (S_Addr == 5'd0) ? 32'h0 : mem_q[S_Addr];
    T = (T_Addr == 5'd0) ? 32'h0 : mem_q[T_Addr];
`ifdef REGFILE32_BYPASS_EN
    // wr_en already excludes R0, so a zero address never forwards.
    if (wr_en && (S_Addr == D_Addr)) begin
      S = D;
    end
    if (wr_en && (T_Addr == D_Addr)) begin
      T = D;
    end
`endif
    // Force zero while reset is held so forwarding cannot leak data out.
    if (!reset) begin
      S = 32'h0;
      T = 32'h0;
    end
  end

endmodule

// File: tb/tb_regfile32.sv
// tb/tb_regfile32.sv - directed self-checking bench for regfile32

module tb_regfile32;

  logic        clk;
  logic        reset;
  logic [4:0]  S_Addr;
  logic [4:0]  T_Addr;
  logic [4:0]  D_Addr;
  logic [31:0] D;
  logic        D_En;
  logic [31:0] S;
  logic [31:0] T;

  int tests;
  int fails;

  regfile32 dut (
    .clk    (clk),
    .reset  (reset),
    .S_Addr (S_Addr),
    .T_Addr (T_Addr),
    .D_Addr (D_Addr),
    .D      (D),
    .D_En   (D_En),
    .S      (S),
    .T      (T)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    D_En   = 1'b1;
    D_Addr = a;
    D      = d;
    @(posedge clk);
    #1;
    D_En   = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return ((~v) << 8) + (32'hFFFF0000 * v) + v;
  endfunction

  logic [31:0] pre7;

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b0;
    S_Addr = 5'd3;
    T_Addr = 5'd31;
    D_Addr = 5'd0;
    D      = 32'h0;
    D_En   = 1'b0;

    // Reset state
    #2;
    check("reset_S_R3", S, 32'h0);
    check("reset_T_R31", T, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_reset_S", S, 32'h0);

    // Load R1..R31 with their index
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    for (int i = 0; i < 16; i++) begin
      S_Addr = 5'(i);
      T_Addr = 5'(i + 16);
      #1;
      check($sformatf("idx_S_%0d", i), S, 32'(i));
      check($sformatf("idx_T_%0d", i + 16), T, 32'(i + 16));
    end

    // Write to R0 is ignored
    wr(5'd0, 32'hDEADBEEF);
    S_Addr = 5'd0;
    T_Addr = 5'd0;
    #1;
    check("r0_S_after_write", S, 32'h0);
    check("r0_T_after_write", T, 32'h0);

    // Pattern load
    for (int i = 1; i < 32; i++) wr(5'(i), pat(i));
    S_Addr = 5'd1; T_Addr = 5'd2; #1;
    check("pat_R1", S, 32'hFFFEFE01);
    check("pat_R2", T, 32'hFFFDFD02);
    S_Addr = 5'd31; T_Addr = 5'd31; #1;
    check("pat_R31_S", S, 32'hFFE0E01F);
    check("pat_R31_T", T, 32'hFFE0E01F);
    for (int i = 1; i < 32; i++) begin
      S_Addr = 5'(i);
      #1;
      check($sformatf("pat_all_R%0d", i), S, pat(i));
    end

    // D_En=0 holds contents
    @(negedge clk);
    D_En = 1'b0; D_Addr = 5'd5; D = 32'hFFFFFFFF;
    repeat (4) @(posedge clk);
    #1;
    S_Addr = 5'd5; #1;
    check("hold_R5", S, 32'hFFFAFA05);

    // Same-cycle write of R7 with read of R7 on S and R8 on T
    pre7 = pat(7);
    @(negedge clk);
    S_Addr = 5'd7; T_Addr = 5'd8;
    D_En = 1'b1; D_Addr = 5'd7; D = 32'h12345678;
    #1;
`ifdef REGFILE32_BYPASS_EN
    check("r7_pre_edge", S, 32'h12345678);
`else
    check("r7_pre_edge", S, pre7);
`endif
    check("r8_no_interact_pre", T, pat(8));
    @(posedge clk);
    #1;
    D_En = 1'b0;
    #1;
    check("r7_post_edge", S, 32'h12345678);
    check("r8_no_interact_post", T, pat(8));

    // Asynchronous reset mid-cycle, writes blocked while held
    @(negedge clk);
    #2;
    reset = 1'b0;
    D_En = 1'b1; D_Addr = 5'd9; D = 32'hA5A5A5A5;
    #1;
    for (int i = 0; i < 32; i++) begin
      S_Addr = 5'(i);
      T_Addr = 5'(31 - i);
      #0.1;
      check($sformatf("rst_S_%0d", i), S, 32'h0);
      check($sformatf("rst_T_%0d", 31 - i), T, 32'h0);
    end
    @(posedge clk);
    #1;
    S_Addr = 5'd9; #1;
    check("rst_blocks_write", S, 32'h0);

    // Release mid-cycle with D_En held: no write until next rising edge
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
`ifdef REGFILE32_BYPASS_EN
    check("release_no_write", S, 32'hA5A5A5A5);
`else
    check("release_no_write", S, 32'h0);
`endif
    T_Addr = 5'd7; #1;
    check("release_R7_cleared", T, 32'h0);
    @(posedge clk);
    #1;
    D_En = 1'b0;
    #1;
    check("first_write_after_release", S, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile32.md
REGFILE32 -- requirements
Module: regfile32

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, 32 registers, 5-bit addresses.
REQ-002 clk  input  1  single clock; all register writes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 S_Addr  input  5  read port S address.
REQ-005 T_Addr  input  5  read port T address.
REQ-006 D_Addr  input  5  write port address.
REQ-007 D  input  32  write data.
REQ-008 D_En  input  1  write enable, active-high.
REQ-009 S  output  32  contents of register S_Addr.
REQ-010 T  output  32  contents of register T_Addr.

Function
REQ-011 Storage SHALL be 32 x 32-bit registers, R0..R31.
REQ-012 On rising clk with reset=1 and D_En=1, R[D_Addr] SHALL be loaded with D.
REQ-013 D_En=0 SHALL leave all registers unchanged.
REQ-014 R0 SHALL read as 32'h0 at all times; writes to D_Addr=0 SHALL be ignored.
REQ-015 S and T SHALL be combinational reads, zero-cycle latency from address change.
REQ-016 Both read ports SHALL be independent; S_Addr=T_Addr SHALL give identical S and T.
REQ-017 A write SHALL become visible on S/T immediately after the writing clock edge (same-edge read returns the new value only under REQ-024).
REQ-018 Read addresses SHALL not affect register contents; a read and a write to different addresses in the same cycle SHALL not interact.
REQ-019 All 5-bit address values are legal; no out-of-range case exists.

Reset
REQ-020 reset=0 SHALL clear R1..R31 to 32'h0 immediately, independent of clk.
REQ-021 While reset=0, S and T SHALL read 32'h0 for every address, and writes SHALL be blocked even with D_En=1.
REQ-022 Reset released mid-cycle SHALL not cause a write; the first write occurs at the next rising edge with D_En=1.

Configuration
REQ-023 Macro REGFILE32_BYPASS_EN selects write-to-read forwarding.
REQ-024 With REGFILE32_BYPASS_EN defined: if D_En=1, reset=1, D_Addr!=0 and S_Addr (or T_Addr) equals D_Addr, that port SHALL output D combinationally in the same cycle.
REQ-025 Without REGFILE32_BYPASS_EN: read ports SHALL always output the stored value; the new value appears only after the rising edge.

Verification
REQ-026 Load R1..R31 with value i (D_En=1, one per cycle), read S_Addr=i, T_Addr=i+16 for i=0..15 -> S=i (S=0 for i=0), T=i+16.
REQ-027 Write pattern D=((~i)<<8)+(-65536*i)+i for i=1..31 -> read R1=32'hFFFEFE01, R2=32'hFFFDFD02, R31=32'hFFE0E01F.
REQ-028 Write D=32'hDEADBEEF to D_Addr=0 -> S_Addr=0 reads 32'h0.
REQ-029 After pattern load, pull reset low between clock edges -> S/T read 32'h0 for all addresses at once; D_En=1 during reset writes nothing.
REQ-030 D_En=0, D=32'hFFFFFFFF, D_Addr=5 for several cycles -> R5 unchanged.
REQ-031 D_En=1, D_Addr=S_Addr=7, D=32'h12345678 before the edge -> S=32'h12345678 pre-edge with REGFILE32_BYPASS_EN, old R7 pre-edge without; new value post-edge in both builds.
